// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-channel 3x3 (TAPS-wide) convolution multiply-accumulate.
//
// A weight load writes one bank per channel; each accepted IFM beat is then
// multiplied tap-by-tap against the bank of the current channel. The products
// are summed and accumulated across the group's channels, and the group result
// is emitted as a single-cycle strobe.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cfg_ch         channels per output (0 -> 1, > MAX_CH -> MAX_CH)
//   cfg_signed     two's-complement mode when 1, unsigned when 0
//   cfg_relu       clamp negative results to 0
//                  (all three cfg inputs are sampled on the first weight beat of a load)
//   weight_valid   In_Weight carries one channel's TAPS weights
//   In_Weight      packed weights, tap k at [k*DATA_W +: DATA_W]
//   in_valid       In_IFM carries one channel's window
//   In_IFM         packed pixels, tap k pairs with weight tap k
//   out_valid      single-cycle result strobe
//   Out_OFM        result, 0 whenever out_valid is 0
//   err            single-cycle pulse for each discarded beat
//   dbg_state_o    control FSM state (W_EMPTY=0, LOADING=1, READY=2)
//
// Handshake: valid-only with no backpressure. A beat is offered exactly in the
// cycle its valid is high and is either consumed at that clock edge or
// discarded, and a discarded beat is flagged on err one cycle later. If
// in_valid and weight_valid are both high, in_valid is handled according to
// the current state and the weight beat is always discarded.
//
// Latency: a group's last beat sampled at edge E produces out_valid after E+3.
// The stages are the beat capture at E, the products at E+1, the accumulate at
// E+2 and the output register at E+3.
module conv_mac_engine #(
  parameter  int DATA_W = 8,
  parameter  int TAPS   = 9,
  parameter  int MAX_CH = 4,
  localparam int OUT_W  = 2*DATA_W + $clog2(TAPS*MAX_CH) + 1,
  localparam int CH_W   = $clog2(MAX_CH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic                     cfg_signed,
  input  logic                     cfg_relu,
  input  logic                     weight_valid,
  input  logic [TAPS*DATA_W-1:0]   In_Weight,
  input  logic                     in_valid,
  input  logic [TAPS*DATA_W-1:0]   In_IFM,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         Out_OFM,
  output logic                     err,
  output logic [1:0]               dbg_state_o
);

  localparam int IDX_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

  typedef enum logic [1:0] {W_EMPTY = 2'd0, LOADING = 2'd1, READY = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         w_cnt_q, w_cnt_d, ch_cnt_q, ch_cnt_d, ch_num_q, ch_num_d;
  logic                    signed_q, signed_d, relu_q, relu_d;
  logic                    err_q;

  logic                    in_acc, w_acc, w_blocked, err_d, first_w, last_beat;
  logic [CH_W-1:0]         eff_ch, load_n, w_idx;

  logic [TAPS*DATA_W-1:0]  wbank_q [MAX_CH];
  logic                    s0_valid_q, s0_first_q, s0_last_q, s0_signed_q, s0_relu_q;
  logic [TAPS*DATA_W-1:0]  s0_ifm_q, s0_w_q;
  logic                    s1_valid_q, s1_first_q, s1_last_q, s1_relu_q;
  logic signed [OUT_W-1:0] s1_prod_q [TAPS];
  logic signed [OUT_W-1:0] tree_sum, acc_q;
  logic                    s2_valid_q, s2_relu_q;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        out_q;

  // Widen an operand to OUT_W so every product and sum is exact at that width.
  function automatic logic signed [OUT_W-1:0] ext(input logic [DATA_W-1:0] x, input logic sgn);
    return sgn ? {{(OUT_W-DATA_W){x[DATA_W-1]}}, x} : {{(OUT_W-DATA_W){1'b0}}, x};
  endfunction

  always_comb begin
    eff_ch = cfg_ch;
    if (cfg_ch == '0) eff_ch = CH_W'(1);
    else if (cfg_ch > CH_W'(MAX_CH)) eff_ch = CH_W'(MAX_CH);
  end

  // Next-state logic. READY with a non-zero channel counter means that a
  // group is partially received. A weight beat in that window would corrupt
  // the bank that the rest of the group still reads, so it is rejected.
  always_comb begin
    state_d   = state_q;
    w_cnt_d   = w_cnt_q;
    ch_cnt_d  = ch_cnt_q;
    ch_num_d  = ch_num_q;
    signed_d  = signed_q;
    relu_d    = relu_q;
    w_blocked = (state_q == READY) && (ch_cnt_q != '0);
    in_acc    = in_valid && (state_q == READY);
    w_acc     = weight_valid && !in_valid && !w_blocked;
    err_d     = (in_valid && (state_q != READY)) || (weight_valid && (in_valid || w_blocked));
    first_w   = (state_q != LOADING);
    load_n    = first_w ? eff_ch : ch_num_q;
    w_idx     = first_w ? '0 : w_cnt_q;
    last_beat = in_acc && ((ch_cnt_q + CH_W'(1)) == ch_num_q);

    if (w_acc) begin
      if (first_w) begin
        ch_num_d = eff_ch;
        signed_d = cfg_signed;
        relu_d   = cfg_relu;
      end
      // The beat that completes the load goes straight to READY, so a
      // single-channel load takes one cycle.
      if ((w_idx + CH_W'(1)) == load_n) begin
        state_d = READY;
        w_cnt_d = '0;
      end else begin
        state_d = LOADING;
        w_cnt_d = w_idx + CH_W'(1);
      end
    end

    if (in_acc) ch_cnt_d = last_beat ? '0 : ch_cnt_q + CH_W'(1);
  end

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < TAPS; k++) tree_sum = tree_sum + s1_prod_q[k];
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= W_EMPTY;
      w_cnt_q     <= '0;
      ch_cnt_q    <= '0;
      ch_num_q    <= CH_W'(1);
      signed_q    <= 1'b0;
      relu_q      <= 1'b0;
      err_q       <= 1'b0;
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      ch_cnt_q    <= ch_cnt_d;
      ch_num_q    <= ch_num_d;
      signed_q    <= signed_d;
      relu_q      <= relu_d;
      err_q       <= err_d;
      s0_valid_q  <= in_acc;
      s1_valid_q  <= s0_valid_q;
      s2_valid_q  <= s1_valid_q && s1_last_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_q <= (s2_relu_q && acc_q[OUT_W-1]) ? '0 : acc_q;
      else            out_q <= '0;
    end
  end

  // Datapath registers. The sign mode, the ReLU flag and the selected weights
  // travel with each beat, so a new load cannot disturb results in flight.
  always_ff @(posedge clk) begin
    if (w_acc) wbank_q[w_idx[IDX_W-1:0]] <= In_Weight;
    if (in_acc) begin
      s0_ifm_q    <= In_IFM;
      s0_w_q      <= wbank_q[ch_cnt_q[IDX_W-1:0]];
      s0_first_q  <= (ch_cnt_q == '0);
      s0_last_q   <= last_beat;
      s0_signed_q <= signed_q;
      s0_relu_q   <= relu_q;
    end
    for (int k = 0; k < TAPS; k++)
      s1_prod_q[k] <= ext(s0_ifm_q[k*DATA_W +: DATA_W], s0_signed_q) *
                      ext(s0_w_q[k*DATA_W +: DATA_W], s0_signed_q);
    s1_first_q <= s0_first_q;
    s1_last_q  <= s0_last_q;
    s1_relu_q  <= s0_relu_q;
    // The first beat of a group replaces the accumulator instead of adding to it.
    if (s1_valid_q) acc_q <= (s1_first_q ? '0 : acc_q) + tree_sum;
    if (s1_valid_q && s1_last_q) s2_relu_q <= s1_relu_q;
  end

  assign out_valid   = out_valid_q;
  assign Out_OFM     = out_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed testbench for conv_mac_engine (DATA_W=8, TAPS=9, MAX_CH=4 -> OUT_W=23).
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the same point.
module tb_conv_mac_engine;

  localparam int DATA_W = 8;
  localparam int TAPS   = 9;
  localparam int MAX_CH = 4;
  localparam int OUT_W  = 23;
  localparam int CH_W   = 3;
  localparam int PW     = TAPS*DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_signed, cfg_relu;
  logic             weight_valid, in_valid;
  logic [PW-1:0]    In_Weight, In_IFM;
  logic             out_valid, err;
  logic [OUT_W-1:0] Out_OFM;
  logic [1:0]       dbg_state;

  int checks = 0;
  int passes = 0;

  // clock/reset block
  always #5 clk = ~clk;

  conv_mac_engine #(.DATA_W(DATA_W), .TAPS(TAPS), .MAX_CH(MAX_CH)) dut (
    .clk(clk), .rst(rst), .cfg_ch(cfg_ch), .cfg_signed(cfg_signed), .cfg_relu(cfg_relu),
    .weight_valid(weight_valid), .In_Weight(In_Weight), .in_valid(in_valid), .In_IFM(In_IFM),
    .out_valid(out_valid), .Out_OFM(Out_OFM), .err(err), .dbg_state_o(dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] fill(input logic [DATA_W-1:0] b);
    return {TAPS{b}};
  endfunction

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input int ch, input bit sg, input bit rl, input logic [PW-1:0] w, input int n);
    cfg_ch = CH_W'(ch);
    cfg_signed = sg;
    cfg_relu = rl;
    for (int i = 0; i < n; i++) begin
      weight_valid = 1'b1;
      In_Weight = w;
      tick();
    end
    weight_valid = 1'b0;
  endtask

  task automatic beat(input logic [PW-1:0] px);
    in_valid = 1'b1;
    In_IFM = px;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the edge that sampled a group's last beat (edge E).
  task automatic expect_result(input string tag, input logic [OUT_W-1:0] val);
    tick(); chk({tag, " E+1 valid"}, OUT_W'(out_valid), '0);
    tick(); chk({tag, " E+2 valid"}, OUT_W'(out_valid), '0);
    tick(); chk({tag, " E+3 valid"}, OUT_W'(out_valid), OUT_W'(1));
            chk({tag, " E+3 ofm"}, Out_OFM, val);
    tick(); chk({tag, " E+4 valid"}, OUT_W'(out_valid), '0);
            chk({tag, " E+4 ofm"}, Out_OFM, '0);
  endtask

  logic [PW-1:0] ramp_w, ramp_p;

  initial begin
    rst = 1'b1; cfg_ch = '0; cfg_signed = 1'b0; cfg_relu = 1'b0;
    weight_valid = 1'b0; in_valid = 1'b0; In_Weight = '0; In_IFM = '0;
    for (int k = 0; k < TAPS; k++) begin
      ramp_w[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
      ramp_p[k*DATA_W +: DATA_W] = DATA_W'(k);
    end

    // Reset held for 2 cycles
    tick(); tick();
    chk("rst out_valid", OUT_W'(out_valid), '0);
    chk("rst ofm", Out_OFM, '0);
    chk("rst err", OUT_W'(err), '0);
    rst = 1'b0;

    // in_valid before any weight load
    beat(fill(8'd5));
    chk("noload err", OUT_W'(err), OUT_W'(1));
    tick();
    chk("noload err clr", OUT_W'(err), '0);
    for (int i = 0; i < 4; i++) begin
      chk("noload out_valid", OUT_W'(out_valid), '0);
      tick();
    end

    // Unsigned, cfg_ch=1, all 255: 9*65025
    load(1, 1'b0, 1'b0, fill(8'hFF), 1);
    beat(fill(8'hFF));
    expect_result("u255", OUT_W'(585225));

    // Signed, cfg_ch=2, all -128 and a 1-cycle gap; the weight beat in the gap is rejected
    load(2, 1'b1, 1'b0, fill(8'h80), 2);
    beat(fill(8'h80));
    weight_valid = 1'b1; In_Weight = fill(8'h01);
    tick();
    weight_valid = 1'b0;
    chk("midgroup w err", OUT_W'(err), OUT_W'(1));
    beat(fill(8'h80));
    chk("midgroup err clr", OUT_W'(err), '0);
    expect_result("s128x2", OUT_W'(294912));

    // Signed, weights -1, IFM 1: -9, then ReLU clamps it to 0
    load(1, 1'b1, 1'b0, fill(8'hFF), 1);
    beat(fill(8'h01));
    expect_result("neg9", OUT_W'(-9));
    load(1, 1'b1, 1'b1, fill(8'hFF), 1);
    beat(fill(8'h01));
    expect_result("relu", '0);

    // Back-to-back single-channel groups with per-tap weights 1..9
    load(1, 1'b0, 1'b0, ramp_w, 1);
    beat(fill(8'd1));  // 1+2+..+9 = 45
    beat(ramp_p);      // sum k*(k+1), k=0..8 = 240
    tick(); chk("b2b E+2 valid", OUT_W'(out_valid), '0);
    tick(); chk("b2b A valid", OUT_W'(out_valid), OUT_W'(1));
            chk("b2b A ofm", Out_OFM, OUT_W'(45));
    tick(); chk("b2b B valid", OUT_W'(out_valid), OUT_W'(1));
            chk("b2b B ofm", Out_OFM, OUT_W'(240));
    tick(); chk("b2b end valid", OUT_W'(out_valid), '0);

    // cfg_ch=0 is treated as 1 channel: 9*2*3
    load(0, 1'b0, 1'b0, fill(8'd2), 1);
    beat(fill(8'd3));
    expect_result("ch0", OUT_W'(54));

    // cfg_ch=7 is clamped to 4 channels: 4*9*1*1
    load(7, 1'b0, 1'b0, fill(8'd1), 4);
    for (int i = 0; i < 3; i++) beat(fill(8'd1));
    beat(fill(8'd1));
    expect_result("clamp", OUT_W'(36));

    // in_valid together with weight_valid in READY: the pixel beat is processed and the weight beat is dropped
    load(1, 1'b0, 1'b0, fill(8'd1), 1);
    weight_valid = 1'b1; In_Weight = fill(8'd9);
    beat(fill(8'd2));
    weight_valid = 1'b0;
    chk("both err", OUT_W'(err), OUT_W'(1));
    expect_result("both", OUT_W'(18));

    // Reset during the second beat of a 2-channel group
    load(2, 1'b0, 1'b0, fill(8'd1), 2);
    beat(fill(8'd1));
    rst = 1'b1;
    beat(fill(8'd1));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rst mid out_valid", OUT_W'(out_valid), '0);
      tick();
    end
    beat(fill(8'd1));
    chk("post rst banks invalid", OUT_W'(err), OUT_W'(1));
    tick(); tick(); tick();
    chk("post rst out_valid", OUT_W'(out_valid), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/conv_mac_engine.md
CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: bit width of each IFM pixel and each weight.
REQ-002 SHALL have parameter TAPS, default 9: number of pixel/weight pairs per beat (3x3 window).
REQ-003 SHALL have parameter MAX_CH, default 4: maximum number of input channels accumulated into one output.
REQ-004 SHALL have derived parameter OUT_W = 2*DATA_W + clog2(TAPS*MAX_CH) + 1, which gives 21 for DATA_W=8, TAPS=9, MAX_CH=1.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk input, 1 bit; rst input, 1 bit.
REQ-006 cfg_ch  input  clog2(MAX_CH+1)  channels per output; sampled on the first weight beat of a load.
REQ-007 cfg_signed  input  1  two's-complement mode when 1, unsigned when 0; sampled with cfg_ch.
REQ-008 cfg_relu  input  1  clamp negative results to 0; sampled with cfg_ch.
REQ-009 weight_valid  input  1  In_Weight carries one channel's TAPS weights.
REQ-010 In_Weight  input  TAPS*DATA_W  packed weights; tap k occupies bits [k*DATA_W +: DATA_W].
REQ-011 in_valid  input  1  In_IFM carries one channel's window.
REQ-012 In_IFM  input  TAPS*DATA_W  packed pixels; tap k pairs with weight tap k.
REQ-013 out_valid  output  1  single-cycle result strobe.
REQ-014 Out_OFM  output  OUT_W  result; sign-extended in signed mode, zero-extended in unsigned mode.
REQ-015 err  output  1  single-cycle pulse for each ignored beat.

Function
REQ-016 The control FSM SHALL have three states: W_EMPTY (reset), LOADING, and READY.
- W_EMPTY -> LOADING on weight_valid.
- LOADING -> READY after the effective channel count of weight beats.
- READY -> LOADING on weight_valid while no group is in progress.
REQ-017 The effective channel count SHALL be computed as follows.
- cfg_ch=0: treated as 1.
- cfg_ch>MAX_CH: clamped to MAX_CH.
REQ-018 Weight beat i of a load SHALL be written to weight bank i, counting from 0.
REQ-019 Starting a new load from READY SHALL invalidate all banks until the new load completes.
REQ-020 in_valid beats SHALL be accepted only in READY.
- Each accepted beat uses bank c, where c is the channel counter.
- The channel counter increments per accepted beat and wraps to 0 after the last channel.
- The beat that wraps the counter ends a group.
REQ-021 Beats within a group need not be consecutive; the channel counter SHALL hold through in_valid=0 cycles.
REQ-022 The pipeline SHALL be registered in three stages.
- Stage 1: TAPS products.
- Stage 2: adder-tree sum added to the running accumulator.
- Stage 3: output register.
- Throughput: one beat per cycle; consecutive groups SHALL NOT stall.
REQ-023 If the last beat of a group is sampled at edge E, out_valid SHALL be 1 with a valid Out_OFM from edge E+3 for exactly one cycle.
REQ-024 Out_OFM SHALL be 0 whenever out_valid is 0.
REQ-025 The accumulator SHALL clear at the start of each group, so back-to-back groups do not contaminate each other.
REQ-026 Arithmetic SHALL be exact at OUT_W bits with no saturation or overflow for any legal input.
REQ-027 When cfg_relu=1 and the signed result is below 0, Out_OFM SHALL be 0 while out_valid still pulses.
REQ-028 err SHALL pulse for one cycle, with the beat discarded, in each of these cases:
- in_valid in W_EMPTY or LOADING;
- weight_valid while a group is partially received;
- in_valid and weight_valid both 1 in the same cycle. In this case in_valid is processed per the state and weight_valid is discarded.
REQ-029 Results already in stages 2-3 SHALL complete even if a new weight load starts.

Reset
REQ-030 rst=1 at a clock edge SHALL produce the following in the next cycle:
- out_valid=0, Out_OFM=0, err=0;
- FSM state W_EMPTY;
- channel and weight counters cleared, banks invalid, pipeline valids cleared.
REQ-031 Reset asserted mid-group or mid-load SHALL discard all partial work, with no out_valid afterward until a new load and group complete.
REQ-032 Weight and accumulator datapath registers need not be reset; only control and output registers are reset.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Reset: hold rst 2 cycles -> out_valid=0, Out_OFM=0, err=0.
- Unsigned, cfg_ch=1: load weights all 255, one IFM beat all 255 at edge E -> out_valid at E+3, Out_OFM=585225.
- Signed, cfg_ch=2: weights all -128 on both channels, two IFM beats all -128 with a 1-cycle gap between them -> Out_OFM=294912.
- Signed, cfg_ch=1, weights all -1, IFM all 1:
  - cfg_relu=0 -> Out_OFM=-9 (all ones except the low bits that encode -9, i.e. 0x1FFFF7 at OUT_W=21);
  - cfg_relu=1 -> Out_OFM=0 with out_valid=1.
- in_valid before any weight load -> err=1 for 1 cycle, no out_valid.
- Back-to-back, cfg_ch=1: 2 consecutive beats -> out_valid on 2 consecutive cycles with independent sums.
- rst pulsed during the second beat of a cfg_ch=2 group -> no out_valid.
